// File: rtl/subadd_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package subadd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit-counter width; never below one bit, even for WIDTH=2.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder used as the single arithmetic stage of serial_subadd.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_subadd.sv
// Bit-serial add/subtract (LSB first) with valid/ready channels and ALU flags.
// Optional sticky overflow flag with clear input: define SUBADD_STICKY_OF_EN.
module serial_subadd
    import subadd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
`ifdef SUBADD_STICKY_OF_EN
    input  logic             of_clr,
    output logic             of_sticky,
`endif
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c_reg;
    logic             nz_acc;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             c_out;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    serial_fa_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_reg),
        .s    (sum_bit),
        .cout (c_out)
    );

    // NOTE: sequential state uses <= only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            c_reg     <= 1'b0;
            nz_acc    <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
                        a_sr     <= a;
                        b_sr     <= b ^ {WIDTH{op == OP_SUB}};
                        c_reg    <= (op == OP_SUB);
                        nz_acc   <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c_reg  <= c_out;
                    result <= {sum_bit, result[WIDTH-1:1]};
                    nz_acc <= nz_acc | sum_bit;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // c_reg is the carry into the MSB stage at this point.
                        carry     <= c_out;
                        overflow  <= c_reg ^ c_out;
                        zero      <= ~(nz_acc | sum_bit);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SUBADD_STICKY_OF_EN
    // Set has priority over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_sticky <= 1'b0;
        end else if (out_valid && out_ready && overflow) begin
            of_sticky <= 1'b1;
        end else if (of_clr) begin
            of_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subadd.sv
// Scoreboard bench for serial_subadd (WIDTH=4): directed vectors, backpressure,
// mid-operation reset and an exhaustive sweep against a 5-bit reference.
module tb_serial_subadd;
    import subadd_pkg::*;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             op = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
`ifdef SUBADD_STICKY_OF_EN
    logic             of_clr = 1'b0;
    logic             of_sticky;
`endif

    serial_subadd #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
`ifdef SUBADD_STICKY_OF_EN
        .of_clr    (of_clr),
        .of_sticky (of_sticky),
`endif
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
        int               acc_edge;
        string            tag;
    } exp_t;

    typedef struct {
        logic             o;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
        string            tag;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic v, input logic z);
        exp_t e;
        e.r = r; e.c = c; e.v = v; e.z = z;
        e.acc_edge = 0;
        e.tag = "";
        return e;
    endfunction

    // Independent reference: 5-bit sum of A and (B or ~B) plus op.
    function automatic exp_t model(input logic o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   s;
        bb = bv ^ {WIDTH{o}};
        s  = {1'b0, av} + {1'b0, bb} + (WIDTH+1)'(o);
        return mk(s[WIDTH-1:0], s[WIDTH],
                  (av[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != av[WIDTH-1]),
                  s[WIDTH-1:0] == '0);
    endfunction

    task automatic issue(input logic o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input exp_t e_in, input string tag);
        exp_t e;
        int   tries = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; b = bv;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = e_in;
        e.acc_edge = cyc + 1;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        op = 1'($urandom);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: latency on the rising out_valid, field compare on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
                else check({sb[0].tag, "_latency"}, 32'(cyc), 32'(sb[0].acc_edge + WIDTH));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_result"},   32'(result),   32'(mon_e.r));
                check({mon_e.tag, "_carry"},    32'(carry),    32'(mon_e.c));
                check({mon_e.tag, "_overflow"}, 32'(overflow), 32'(mon_e.v));
                check({mon_e.tag, "_zero"},     32'(zero),     32'(mon_e.z));
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_carry"},     32'(carry),     32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
        check({tag, "_zero"},      32'(zero),      32'd0);
`ifdef SUBADD_STICKY_OF_EN
        check({tag, "_of_sticky"}, 32'(of_sticky), 32'd0);
`endif
    endtask

    vec_t dir[5];
    int   t;

    initial begin
        dir[0] = '{o: OP_ADD, a: 4'h7, b: 4'h1, r: 4'h8, c: 1'b0, v: 1'b1, z: 1'b0, tag: "add_7_1"};
        dir[1] = '{o: OP_SUB, a: 4'h5, b: 4'h5, r: 4'h0, c: 1'b1, v: 1'b0, z: 1'b1, tag: "sub_5_5"};
        dir[2] = '{o: OP_SUB, a: 4'h3, b: 4'h5, r: 4'hE, c: 1'b0, v: 1'b0, z: 1'b0, tag: "sub_3_5"};
        dir[3] = '{o: OP_SUB, a: 4'h8, b: 4'h1, r: 4'h7, c: 1'b1, v: 1'b1, z: 1'b0, tag: "sub_8_1"};
        dir[4] = '{o: OP_ADD, a: 4'hF, b: 4'h1, r: 4'h0, c: 1'b1, v: 1'b0, z: 1'b1, tag: "add_F_1"};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        issue(dir[0].o, dir[0].a, dir[0].b, mk(dir[0].r, dir[0].c, dir[0].v, dir[0].z), dir[0].tag);
        drain("add_7_1");
`ifdef SUBADD_STICKY_OF_EN
        check("sticky_set", 32'(of_sticky), 32'd1);
        @(negedge clk) of_clr = 1'b1;
        @(negedge clk) of_clr = 1'b0;
        check("sticky_clr", 32'(of_sticky), 32'd0);
`endif

        // Back-to-back directed operations.
        for (int i = 1; i < 5; i++)
            issue(dir[i].o, dir[i].a, dir[i].b, mk(dir[i].r, dir[i].c, dir[i].v, dir[i].z), dir[i].tag);
        drain("directed");

        // Backpressure: result held, new requests ignored.
        @(posedge clk); #1 out_ready = 1'b0;
        issue(OP_SUB, 4'h3, 4'h5, mk(4'hE, 1'b0, 1'b0, 1'b0), "bp");
        t = 0;
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result",    32'(result),    32'hE);
            check("bp_flags",     32'({carry, overflow, zero}), 32'd0);
            in_valid = ~in_valid; op = OP_ADD; a = 4'h1; b = 4'h1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        repeat (8) @(negedge clk);
        check("bp_second_op_ignored", 32'(out_valid), 32'd0);

        // Asynchronous reset during the second SHIFT cycle.
        issue(OP_SUB, 4'h5, 4'h5, mk(4'h0, 1'b1, 1'b0, 1'b1), "pre_rst_sub_5_5");
        drain("pre_rst");
        issue(OP_ADD, 4'hF, 4'hF, mk(4'hE, 1'b1, 1'b0, 1'b0), "rst_victim");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_shift_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(OP_ADD, 4'h2, 4'h3, mk(4'h5, 1'b0, 1'b0, 1'b0), "add_2_3");
        drain("add_2_3");

        // Exhaustive sweep against the reference model.
        for (int o = 0; o < 2; o++)
            for (int ai = 0; ai < 16; ai++)
                for (int bi = 0; bi < 16; bi++)
                    issue(1'(o), 4'(ai), 4'(bi), model(1'(o), 4'(ai), 4'(bi)),
                          $sformatf("exh_op%0d_%h_%h", o, ai, bi));
        drain("exhaustive");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
